// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and constants for the transmit and
//                receive paths.
//  Revision    : 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Baud counter; pulses bit_tick on the last clock of each bit.
//  Revision    : 1.0
// ============================================================================
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int                 c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Held in clear, the counter sits at zero and must not report a boundary.
    assign bit_tick = w_wrap && !clear;

endmodule : uart_bit_timer
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl
//  Description : UART transmit frame sequencer (start, 8 data LSB first,
//                1 or 2 stop bits) with a valid/ready byte interface.
//  Revision    : 1.0
// ============================================================================
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int               c_idx_w    = $clog2(UART_DATA_BITS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(UART_DATA_BITS - 1);
    localparam logic             c_stop_last = 1'(STOP_BITS - 1);

    tx_state_t                 r_state, w_state_next;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_next;
    logic [c_idx_w-1:0]        r_bit_idx, w_bit_idx_next;
    logic                      r_stop_cnt, w_stop_cnt_next;
    logic                      r_tx, w_tx_next;
    logic                      r_done, w_done_next;
    logic                      w_tick;
    logic                      w_xfer;
    logic                      w_idle;

    assign w_idle = (r_state == IDLE);
    assign w_xfer = tx_valid && w_idle;

    // The timer is held at zero throughout IDLE so the start bit gets a full period.
    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_idle),
        .bit_tick (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_tx       <= w_tx_next;
            r_done     <= w_done_next;
        end
    end

    // tx is computed for the next state so the line changes on the same edge as the FSM.
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_tx_next       = r_tx;
        w_done_next     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (w_xfer) begin
                    w_state_next    = START;
                    w_shift_next    = tx_data;
                    w_bit_idx_next  = '0;
                    w_stop_cnt_next = 1'b0;
                    w_tx_next       = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = '0;
                    w_tx_next      = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next   = {1'b0, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == c_last_idx) begin
                        w_state_next    = STOP;
                        w_stop_cnt_next = 1'b0;
                        w_tx_next       = 1'b1;
                    end else begin
                        w_tx_next = r_shift[1];
                    end
                end
            end
            STOP: begin
                w_tx_next = 1'b1;
                if (w_tick) begin
                    if (r_stop_cnt == c_stop_last) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_stop_cnt_next = r_stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    assign tx_ready = w_idle;
    assign busy     = !w_idle;
    assign tx       = r_tx;
    assign done     = r_done;

endmodule : uart_tx_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_ctrl
//  Description : Self-checking bench for uart_tx_ctrl (N=4, one and two stop bits).
//  Revision    : 1.0
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_i   [2];
    logic [7:0] data_i  [2];
    logic       valid_i [2];
    logic       ready_w [2];
    logic       tx_w    [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(N), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset(rst_i[0]), .tx_data(data_i[0]), .tx_valid(valid_i[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(N), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(rst_i[1]), .tx_data(data_i[1]), .tx_valid(valid_i[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of a frame carrying b, c clocks after the handshake edge.
    function automatic logic model_tx(input logic [7:0] b, input int c);
        int k;
        if (c <= N)     return 1'b0;
        if (c <= 9 * N) begin
            k = (c - 1) / N - 1;
            return b[k];
        end
        return 1'b1;
    endfunction

    task automatic check_idle(input int sel, input string tag);
        check($sformatf("%s.tx[%0d]",    tag, sel), 8'(tx_w[sel]),    8'd1);
        check($sformatf("%s.ready[%0d]", tag, sel), 8'(ready_w[sel]), 8'd1);
        check($sformatf("%s.busy[%0d]",  tag, sel), 8'(busy_w[sel]),  8'd0);
        check($sformatf("%s.done[%0d]",  tag, sel), 8'(done_w[sel]),  8'd0);
    endtask

    task automatic start(input int sel, input logic [7:0] b);
        @(negedge clk);
        data_i[sel]  = b;
        valid_i[sel] = 1'b1;
    endtask

    // mess: 0 quiet inputs, 1 data=0x3C with valid toggling, 2 random inputs.
    task automatic run_frame(input int sel, input logic [7:0] b, input bit hold,
                             input logic [7:0] nxt, input int mess, input int abort_at);
        int  s;
        int  p;
        bit  exp_busy;
        s = sel + 1;
        p = (9 + s) * N + 1;
        @(posedge clk);
        for (int c = 1; c <= p; c++) begin
            @(negedge clk);
            exp_busy = (c <= (9 + s) * N);
            check($sformatf("tx[%0d] b=%0h c=%0d",    sel, b, c), 8'(tx_w[sel]),    8'(model_tx(b, c)));
            check($sformatf("busy[%0d] b=%0h c=%0d",  sel, b, c), 8'(busy_w[sel]),  8'(exp_busy));
            check($sformatf("ready[%0d] b=%0h c=%0d", sel, b, c), 8'(ready_w[sel]), 8'(!exp_busy));
            check($sformatf("done[%0d] b=%0h c=%0d",  sel, b, c), 8'(done_w[sel]),  8'(c == p));
            if (abort_at != 0 && c == abort_at) break;
            if (mess == 1 && c < p - 1) begin
                data_i[sel]  = 8'h3C;
                valid_i[sel] = 1'(c % 2);
            end else if (mess == 2 && c < p - 1) begin
                data_i[sel]  = 8'($urandom);
                valid_i[sel] = 1'($urandom_range(0, 1));
            end else begin
                valid_i[sel] = hold;
                if (hold) data_i[sel] = nxt;
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] b2;
        int         sel;

        rst_i   = '{1'b1, 1'b1};
        valid_i = '{1'b0, 1'b0};
        data_i  = '{8'h00, 8'h00};

        // Reset behaviour, during and after.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle(0, "in_reset");
            check_idle(1, "in_reset");
        end
        rst_i = '{1'b0, 1'b0};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_idle(0, "post_reset");
            check_idle(1, "post_reset");
        end

        // 0xA5, one stop bit.
        start(0, 8'hA5);
        run_frame(0, 8'hA5, 1'b0, 8'h00, 0, 0);

        // Back-to-back 0x00 then 0xFF with valid held.
        start(0, 8'h00);
        run_frame(0, 8'h00, 1'b1, 8'hFF, 0, 0);
        run_frame(0, 8'hFF, 1'b0, 8'h00, 0, 0);

        // Mid-frame input changes are ignored.
        start(0, 8'hA5);
        run_frame(0, 8'hA5, 1'b0, 8'h00, 1, 0);

        // Reset during data bit 3: line must go high without waiting for a clock.
        start(0, 8'hA5);
        run_frame(0, 8'hA5, 1'b0, 8'h00, 0, 18);
        valid_i[0] = 1'b0;
        #2 rst_i[0] = 1'b1;
        #1 check_idle(0, "async_reset");
        @(negedge clk);
        check_idle(0, "held_reset");
        rst_i[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_idle(0, "after_abort");
        end
        start(0, 8'h5A);
        run_frame(0, 8'h5A, 1'b0, 8'h00, 0, 0);

        // Two stop bits.
        start(1, 8'hFF);
        run_frame(1, 8'hFF, 1'b0, 8'h00, 0, 0);

        // Randomised frames, either stop-bit configuration.
        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 1));
            b   = 8'($urandom);
            start(sel, b);
            run_frame(sel, b, 1'b0, 8'h00, int'($urandom_range(0, 1)) * 2, 0);
        end
        for (int i = 0; i < 2; i++) begin
            b  = 8'($urandom);
            b2 = 8'($urandom);
            start(i, b);
            run_frame(i, b,  1'b1, b2,    0, 0);
            run_frame(i, b2, 1'b0, 8'h00, 0, 0);
        end

        @(negedge clk);
        check_idle(0, "final");
        check_idle(1, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
`default_nettype wire
